// File: rtl/dtmr_pkg.sv
// Shared types and helpers for the triplicated serial-to-parallel deserialiser.
// Replica state is sized for the largest legal word so one struct serves every WIDTH.
package dtmr_pkg;

    localparam int NREP      = 3;
    localparam int MAX_W     = 32;
    localparam int MAX_CNT_W = 5;

    typedef struct packed {
        logic [MAX_W-1:0]     sr;
        logic [MAX_CNT_W-1:0] cnt;
        logic [MAX_W-1:0]     hold;
        logic                 vld;
    } rep_state_t;

    function automatic logic [MAX_W-1:0] maj3(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic [MAX_W-1:0] c
    );
        return (a & b) | (b & c) | (a & c);
    endfunction

endpackage

// File: rtl/tmr_vote_w.sv
// Bitwise 2-of-3 majority voter of parameterised width.
// Purely combinational, zero latency, no flow control.
module tmr_vote_w #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] y
);

    logic [W-1:0] nor_ab;
    logic [W-1:0] nor_bc;
    logic [W-1:0] nor_ac;

    // Same NOR/OR arrangement as the single-bit voters: y = (a|b)&(b|c)&(a|c).
    assign nor_ab = ~(a | b);
    assign nor_bc = ~(b | c);
    assign nor_ac = ~(a | c);
    assign y      = ~(nor_ab | nor_bc | nor_ac);

endmodule

// File: rtl/dtmr_deser.sv
// Triplicated MSB-first deserialiser: voted bit stream in, WIDTH-bit words out on valid/ready.
// Latency: word valid one cycle after its last bit; in_ready drops while a word is held unconsumed.
// Every replica reloads from the vote, so a single upset is scrubbed the next cycle and counted.
module dtmr_deser
    import dtmr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH),
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             inj_en,
    input  logic [1:0]       inj_rep,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_count
);

    rep_state_t rep_q [NREP];
    rep_state_t rep_d [NREP];
    rep_state_t nxt;
    rep_state_t v;

    logic [MAX_W-1:0]     v_sr;
    logic [MAX_CNT_W-1:0] v_cnt;
    logic [MAX_W-1:0]     v_hold;
    logic                 v_vld;

    tmr_vote_w #(.W(MAX_W)) u_vote_sr (
        .a (rep_q[0].sr),
        .b (rep_q[1].sr),
        .c (rep_q[2].sr),
        .y (v_sr)
    );

    tmr_vote_w #(.W(MAX_CNT_W)) u_vote_cnt (
        .a (rep_q[0].cnt),
        .b (rep_q[1].cnt),
        .c (rep_q[2].cnt),
        .y (v_cnt)
    );

    tmr_vote_w #(.W(MAX_W)) u_vote_hold (
        .a (rep_q[0].hold),
        .b (rep_q[1].hold),
        .c (rep_q[2].hold),
        .y (v_hold)
    );

    tmr_vote_w #(.W(1)) u_vote_vld (
        .a (rep_q[0].vld),
        .b (rep_q[1].vld),
        .c (rep_q[2].vld),
        .y (v_vld)
    );

    always_comb begin
        v      = '0;
        v.sr   = v_sr;
        v.cnt  = v_cnt;
        v.hold = v_hold;
        v.vld  = v_vld;
    end

    logic [WIDTH-1:0] sr_v;
    logic [WIDTH-1:0] hold_v;
    logic [WIDTH-1:0] sr_shift;
    logic [CNT_W-1:0] cnt_v;
    logic             accept;
    logic             done;

    assign sr_v     = v_sr[WIDTH-1:0];
    assign hold_v   = v_hold[WIDTH-1:0];
    assign cnt_v    = v_cnt[CNT_W-1:0];
    assign sr_shift = {sr_v[WIDTH-2:0], in_bit};

    assign in_ready  = !v_vld || out_ready;
    assign accept    = in_valid && in_ready;
    assign done      = accept && (cnt_v == CNT_W'(WIDTH - 1));
    assign out_data  = hold_v;
    assign out_valid = v_vld;

    // Common next state from the vote; a completion while the old word is taken keeps vld high.
    always_comb begin
        nxt      = '0;
        nxt.sr   = MAX_W'(accept ? sr_shift : sr_v);
        nxt.hold = MAX_W'(done ? sr_shift : hold_v);
        nxt.vld  = done || (v_vld && !out_ready);
        if (done) begin
            nxt.cnt = '0;
        end else if (accept) begin
            nxt.cnt = MAX_CNT_W'(cnt_v + CNT_W'(1));
        end else begin
            nxt.cnt = MAX_CNT_W'(cnt_v);
        end
    end

    always_comb begin
        for (int r = 0; r < NREP; r++) begin
            rep_d[r] = nxt;
            if (inj_en && (inj_rep == r[1:0])) begin
                rep_d[r].sr[0] = ~nxt.sr[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREP; r++) begin
                rep_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREP; r++) begin
                rep_q[r] <= rep_d[r];
            end
        end
    end

    logic mismatch;

    always_comb begin
        mismatch = 1'b0;
        for (int r = 0; r < NREP; r++) begin
            if (rep_q[r] != v) begin
                mismatch = 1'b1;
            end
        end
    end

    // Diagnostics only; a corrupted count does not affect the data path.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_flag  <= 1'b0;
            err_count <= '0;
        end else begin
            err_flag <= mismatch;
            if (mismatch && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dtmr_deser.sv
// Directed table-driven bench for dtmr_deser, plus hand sequences for reset and counter saturation.
module tb_dtmr_deser;

    logic       clk;
    logic       rst;
    logic       in_bit;
    logic       in_valid;
    logic       out_ready;
    logic       inj_en;
    logic [1:0] inj_rep;

    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       err_flag;
    logic [7:0] err_count;

    logic       s_in_ready;
    logic [7:0] s_out_data;
    logic       s_out_valid;
    logic       s_err_flag;
    logic [1:0] s_err_count;

    int n_vec;
    int n_bad;

    dtmr_deser #(.WIDTH(8), .ERR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inj_en    (inj_en),
        .inj_rep   (inj_rep),
        .err_flag  (err_flag),
        .err_count (err_count)
    );

    dtmr_deser #(.WIDTH(8), .ERR_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .out_data  (s_out_data),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .inj_en    (inj_en),
        .inj_rep   (inj_rep),
        .err_flag  (s_err_flag),
        .err_count (s_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       b;
        logic       valid;
        logic       ordy;
        logic       inj;
        logic [1:0] rep;
        logic       e_vld;
        logic [7:0] e_data;
        logic       e_rdy;
        logic       e_flag;
        int         e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic b, input logic valid, input logic ordy,
                                input logic inj, input logic [1:0] rep, input logic e_vld,
                                input logic [7:0] e_data, input logic e_rdy,
                                input logic e_flag, input int e_cnt);
        vec_t t;
        t.b = b; t.valid = valid; t.ordy = ordy; t.inj = inj; t.rep = rep;
        t.e_vld = e_vld; t.e_data = e_data; t.e_rdy = e_rdy;
        t.e_flag = e_flag; t.e_cnt = e_cnt;
        vecs.push_back(t);
    endfunction

    // One word with out_ready held high, optional upset at bit inj_idx, followed by one idle cycle.
    function automatic void add_word(input logic [7:0] w, input logic [7:0] prev,
                                     input int inj_idx, input logic [1:0] rep, input int cnt0);
        logic hit;
        hit = (inj_idx >= 0) && (rep != 2'd3);
        for (int i = 0; i < 8; i++) begin
            add(w[7-i], 1'b1, 1'b1, (i == inj_idx), rep, 1'b0, prev, 1'b1,
                hit && (i == inj_idx + 2), (hit && (i >= inj_idx + 2)) ? cnt0 + 1 : cnt0);
        end
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, w, 1'b1, 1'b0, hit ? cnt0 + 1 : cnt0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] w;
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inj_en = 1'b0; inj_rep = 2'd3;
        tick();
        tick();

        // Reset state, observed with out_ready low so in_ready must come from vld=0.
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", 32'(out_data), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst err_flag", 32'(err_flag), 32'd0);
        chk("rst err_count", 32'(err_count), 32'd0);
        chk("rst sat err_count", 32'(s_err_count), 32'd0);
        rst = 1'b0;

        // Basic word 0xB2.
        add_word(8'hB2, 8'h00, -1, 2'd3, 0);

        // Backpressure: 0xB2 again with out_ready low, stall, then 0x5A.
        w = 8'hB2;
        for (int i = 0; i < 8; i++) add(w[7-i], 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'hB2, 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 8'hB2, 1'b0, 1'b0, 0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 8'hB2, 1'b1, 1'b0, 0);
        w = 8'h5A;
        for (int i = 1; i < 8; i++) add(w[7-i], 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'hB2, 1'b1, 1'b0, 0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 8'h5A, 1'b1, 1'b0, 0);

        // Back-to-back 0xFF then 0x00 with in_valid held high throughout.
        for (int i = 0; i < 8; i++) add(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'h5A, 1'b1, 1'b0, 0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
        for (int i = 1; i < 8; i++) add(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'hFF, 1'b1, 1'b0, 0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 8'h00, 1'b1, 1'b0, 0);

        // Single upsets in each replica, then the no-effect selector.
        add_word(8'h3C, 8'h00, 3, 2'd1, 0);
        add_word(8'h3C, 8'h3C, 3, 2'd0, 1);
        add_word(8'h3C, 8'h3C, 3, 2'd2, 2);
        add_word(8'h3C, 8'h3C, 3, 2'd3, 3);

        for (int i = 0; i < vecs.size(); i++) begin
            in_bit    = vecs[i].b;
            in_valid  = vecs[i].valid;
            out_ready = vecs[i].ordy;
            inj_en    = vecs[i].inj;
            inj_rep   = vecs[i].rep;
            @(negedge clk);
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_vld));
            chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].e_data));
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d err_flag", i), 32'(err_flag), 32'(vecs[i].e_flag));
            chk($sformatf("vec%0d err_count", i), 32'(err_count), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d sat out_data", i), 32'(s_out_data), 32'(vecs[i].e_data));
            chk($sformatf("vec%0d sat out_valid", i), 32'(s_out_valid), 32'(vecs[i].e_vld));
            chk($sformatf("vec%0d sat in_ready", i), 32'(s_in_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d sat err_flag", i), 32'(s_err_flag), 32'(vecs[i].e_flag));
            chk($sformatf("vec%0d sat err_count", i), 32'(s_err_count),
                32'(vecs[i].e_cnt > 3 ? 3 : vecs[i].e_cnt));
            @(posedge clk);
            #1;
        end
        inj_en = 1'b0; inj_rep = 2'd3; in_valid = 1'b0;

        // Reset mid-word with a bit offered and an injection requested in the reset cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_bit = 1'b1; in_valid = 1'b1;
            tick();
        end
        rst = 1'b1; inj_en = 1'b1; inj_rep = 2'd0;
        tick();
        rst = 1'b0; inj_en = 1'b0; inj_rep = 2'd3; in_valid = 1'b0; out_ready = 1'b0;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out_data", 32'(out_data), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst err_count", 32'(err_count), 32'd0);
        tick();
        chk("midrst err_flag", 32'(err_flag), 32'd0);
        chk("midrst err_count later", 32'(err_count), 32'd0);
        out_ready = 1'b1;
        w = 8'h96;
        for (int i = 0; i < 8; i++) begin
            in_bit = w[7-i]; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("postrst out_valid", 32'(out_valid), 32'd1);
        chk("postrst out_data", 32'(out_data), 32'h96);
        tick();
        chk("postrst consumed", 32'(out_valid), 32'd0);

        // Counter saturation on the ERR_W=2 instance, five isolated upsets.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            inj_en = 1'b1; inj_rep = 2'(k % 3);
            tick();
            inj_en = 1'b0; inj_rep = 2'd3;
            chk($sformatf("sat%0d flag before", k), 32'(err_flag), 32'd0);
            tick();
            chk($sformatf("sat%0d flag pulse", k), 32'(err_flag), 32'd1);
            chk($sformatf("sat%0d err_count", k), 32'(err_count), 32'(k + 1));
            chk($sformatf("sat%0d sat err_count", k), 32'(s_err_count), 32'(k + 1 > 3 ? 3 : k + 1));
            tick();
            chk($sformatf("sat%0d flag after", k), 32'(err_flag), 32'd0);
        end
        for (int i = 0; i < 4; i++) tick();
        chk("sat final err_count", 32'(err_count), 32'd5);
        chk("sat final sat err_count", 32'(s_err_count), 32'd3);
        chk("sat final out_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
